// File: rtl/hex_flash_multi.sv
// Multi-digit seven-segment flasher: blinks a latched subset of digits for a
// programmable number of blank/show pairs, then returns to live pass-through.
module hex_flash_multi #(
    parameter int N_DIGITS    = 6,
    parameter int HALF_PERIOD = 16,
    parameter int FLASHES     = 6,
    parameter bit RETRIGGER   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic                  stop,
    input  logic [N_DIGITS-1:0]   mask,
    input  logic [7*N_DIGITS-1:0] HEXin,
    output logic [7*N_DIGITS-1:0] HEXout,
    output logic                  busy,
    output logic                  done
);

    localparam int RW_RAW = $clog2(HALF_PERIOD);
    localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;
    localparam int FW_RAW = $clog2(FLASHES + 1);
    localparam int FW     = (FW_RAW < 1) ? 1 : FW_RAW;

    localparam int FLASH_LAST_I = (FLASHES > 0) ? FLASHES - 1 : 0;

    localparam logic [RW-1:0] RATE_LAST  = RW'(HALF_PERIOD - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_LAST_I);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t              state, state_n;
    logic [RW-1:0]       rate_cnt, rate_n;
    logic [FW-1:0]       flash_cnt, flash_n;
    logic [N_DIGITS-1:0] mask_q, mask_n;
    logic                done_n;
    logic                start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rate_cnt  <= '0;
            flash_cnt <= '0;
            mask_q    <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            rate_cnt  <= rate_n;
            flash_cnt <= flash_n;
            mask_q    <= mask_n;
            done      <= done_n;
        end
    end

    // stop has priority over any start; a busy trigger only restarts when RETRIGGER is set
    assign start = trigger && !stop && ((state == IDLE) || RETRIGGER);

    always_comb begin
        state_n = state;
        rate_n  = rate_cnt;
        flash_n = flash_cnt;
        mask_n  = mask_q;
        done_n  = 1'b0;

        if (stop && (state != IDLE)) begin
            state_n = IDLE;
            rate_n  = '0;
            flash_n = '0;
        end else if (start) begin
            state_n = BLANK;
            rate_n  = '0;
            flash_n = '0;
            mask_n  = mask;
        end else begin
            case (state)
                BLANK: begin
                    if (rate_cnt == RATE_LAST) begin
                        state_n = SHOW;
                        rate_n  = '0;
                    end else begin
                        rate_n = rate_cnt + RW'(1);
                    end
                end
                SHOW: begin
                    if (rate_cnt == RATE_LAST) begin
                        rate_n = '0;
                        if ((FLASHES != 0) && (flash_cnt == FLASH_LAST)) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = BLANK;
                            // infinite mode pins the flash counter at zero
                            flash_n = (FLASHES == 0) ? '0 : flash_cnt + FW'(1);
                        end
                    end else begin
                        rate_n = rate_cnt + RW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        HEXout = HEXin;
        for (int i = 0; i < N_DIGITS; i++) begin
            if ((state == BLANK) && mask_q[i]) begin
                HEXout[7*i +: 7] = 7'h7F;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hex_flash_multi.sv
// Scoreboard bench for hex_flash_multi: a finite retriggering instance and an
// infinite non-retriggering instance share stimulus and are checked against a timeline model.
module tb_hex_flash_multi;

    localparam int ND   = 2;
    localparam int HP_A = 4;
    localparam int FL_A = 3;
    localparam int HP_B = 3;
    localparam int FL_B = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          trigger = 1'b0;
    logic          stop = 1'b0;
    logic [ND-1:0] mask = '0;
    logic [13:0]   HEXin = 14'h2A55;
    logic [13:0]   hexA, hexB;
    logic          busyA, busyB, doneA, doneB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [13:0] hexA;
        logic [13:0] hexB;
        logic        busyA;
        logic        busyB;
        logic        doneA;
        logic        doneB;
    } exp_t;

    exp_t expq[$];

    // Model: a sequence is a timeline of k cycles since the starting edge
    bit      m_active[2];
    int      m_k[2];
    logic [1:0] m_mask[2];
    bit      m_done[2];
    int      m_hp[2];
    int      m_fl[2];
    bit      m_rt[2];

    always #5 clk = ~clk;

    hex_flash_multi #(.N_DIGITS(ND), .HALF_PERIOD(HP_A), .FLASHES(FL_A), .RETRIGGER(1'b1)) dutA (
        .clk(clk), .reset(reset), .trigger(trigger), .stop(stop), .mask(mask),
        .HEXin(HEXin), .HEXout(hexA), .busy(busyA), .done(doneA)
    );

    hex_flash_multi #(.N_DIGITS(ND), .HALF_PERIOD(HP_B), .FLASHES(FL_B), .RETRIGGER(1'b0)) dutB (
        .clk(clk), .reset(reset), .trigger(trigger), .stop(stop), .mask(mask),
        .HEXin(HEXin), .HEXout(hexB), .busy(busyB), .done(doneB)
    );

    function automatic logic [13:0] expHex(int i, logic [13:0] hin);
        logic [13:0] r;
        r = hin;
        if (m_active[i] && (((m_k[i] / m_hp[i]) % 2) == 0)) begin
            for (int d = 0; d < ND; d++) begin
                if (m_mask[i][d]) r[7*d +: 7] = 7'h7F;
            end
        end
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_k[i]      = 0;
            m_mask[i]   = '0;
            m_done[i]   = 1'b0;
        end
    endtask

    task automatic modelStep(int i, logic trig, logic stp, logic [1:0] msk);
        m_done[i] = 1'b0;
        if (stp) begin
            m_active[i] = 1'b0;
        end else if (trig && (!m_active[i] || m_rt[i])) begin
            m_active[i] = 1'b1;
            m_k[i]      = 0;
            m_mask[i]   = msk;
        end else if (m_active[i]) begin
            m_k[i]++;
            if ((m_fl[i] != 0) && (m_k[i] == 2 * m_hp[i] * m_fl[i])) begin
                m_active[i] = 1'b0;
                m_done[i]   = 1'b1;
            end
        end
    endtask

    // One cycle: drive just after an edge, record what the next negedge must show, advance the model
    task automatic applyStimulus(logic rst, logic trig, logic stp, logic [1:0] msk, logic [13:0] hin);
        exp_t e;
        reset   = rst;
        trigger = trig;
        stop    = stp;
        mask    = msk;
        HEXin   = hin;
        if (rst) modelReset();
        e.hexA  = expHex(0, hin);
        e.hexB  = expHex(1, hin);
        e.busyA = m_active[0];
        e.busyB = m_active[1];
        e.doneA = m_done[0];
        e.doneB = m_done[1];
        expq.push_back(e);
        if (!rst) begin
            modelStep(0, trig, stp, msk);
            modelStep(1, trig, stp, msk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [13:0] actual, logic [13:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic idleCycles(int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, 1'b0, 1'b0, 2'($urandom), 14'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                checkOutput("hexA", hexA, e.hexA);
                checkOutput("hexB", hexB, e.hexB);
                checkOutput("busyA", {13'b0, busyA}, {13'b0, e.busyA});
                checkOutput("busyB", {13'b0, busyB}, {13'b0, e.busyB});
                checkOutput("doneA", {13'b0, doneA}, {13'b0, e.doneA});
                checkOutput("doneB", {13'b0, doneB}, {13'b0, e.doneB});
            end
        end
    end

    initial begin : stimulus
        m_hp[0] = HP_A; m_fl[0] = FL_A; m_rt[0] = 1'b1;
        m_hp[1] = HP_B; m_fl[1] = FL_B; m_rt[1] = 1'b0;
        modelReset();
        @(posedge clk);
        #1;

        // reset pass-through
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 14'h2A55);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 14'h2A55);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 14'h2A55);

        // full sequence, digit0 only, mask changes mid-run are ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 14'($urandom));
        idleCycles(30);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 14'($urandom));

        // abort on cycle 6, then trigger+stop together in idle
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 14'($urandom));
        idleCycles(5);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 14'($urandom));
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 14'($urandom));
        idleCycles(3);

        // retrigger at cycle 10 with a new mask
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 14'($urandom));
        idleCycles(9);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 14'($urandom));
        idleCycles(110);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 14'($urandom));
        idleCycles(2);

        // trigger held high for a long stretch
        for (int c = 0; c < 60; c++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 14'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 14'($urandom));

        // async reset mid-BLANK, then a fresh sequence
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 14'($urandom));
        idleCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 14'($urandom));
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 14'($urandom));
        idleCycles(30);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 59) == 0),
                          2'($urandom), 14'($urandom));
        end

        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
